// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared period counter, per-channel comparators,
// double-buffered duties that only take effect on a period boundary.
module pwm_multi_gen #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned PWM_FREQ = 20000,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned CENTER   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DUTY_W-1:0] duty_in,
    input  logic                     duty_load,
    input  logic                     enable,
    output logic [NUM_CH-1:0]        pwm_out,
    output logic                     period_start,
    output logic                     load_ack
);

    localparam int unsigned M      = CLK_FREQ / PWM_FREQ;
    localparam int unsigned CNT_W  = $clog2(M);
    localparam int unsigned PROD_W = DUTY_W + CNT_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     dir_q, dir_d;
    logic [NUM_CH*DUTY_W-1:0] pend_q, pend_d;
    logic [NUM_CH*DUTY_W-1:0] act_q, act_d;
    logic                     pflag_q, pflag_d;
    logic                     armed_q, armed_d;
    logic [NUM_CH-1:0]        pwm_q, pwm_d;
    logic                     ps_q;
    logic                     ack_q, ack_d;
    logic                     boundary;
    logic [NUM_CH-1:0]        hit;

    // Full-width product so the top duty code still lands strictly below M.
    function automatic logic [PROD_W-1:0] thr_of(input logic [DUTY_W-1:0] duty);
        return (PROD_W'(duty) * PROD_W'(M)) >> DUTY_W;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (CENTER == 0) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q - CNT_ONE;
                // With M == 2 the down ramp is empty; stay counting up.
                dir_d = (M > 2) ? DIR_DOWN : DIR_UP;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                dir_d = DIR_UP;
            end
        end
    end

    assign boundary = (cnt_d == '0);

    always_comb begin
        act_d   = act_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        ack_d   = 1'b0;
        if (duty_load && boundary) begin
            act_d   = duty_in;
            pend_d  = duty_in;
            pflag_d = 1'b0;
            ack_d   = 1'b1;
        end else if (boundary && pflag_q) begin
            act_d   = pend_q;
            pflag_d = 1'b0;
            ack_d   = 1'b1;
        end else if (duty_load) begin
            pend_d  = duty_in;
            pflag_d = 1'b1;
        end
    end

    // Disarm is immediate; arming waits for a boundary so no partial first pulse.
    always_comb begin
        armed_d = armed_q;
        if (!enable) begin
            armed_d = 1'b0;
        end else if (boundary) begin
            armed_d = 1'b1;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            hit[i] = PROD_W'(cnt_q) < thr_of(act_q[i*DUTY_W +: DUTY_W]);
        end
        pwm_d = armed_q ? hit : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            pend_q  <= '0;
            act_q   <= '0;
            pflag_q <= 1'b0;
            armed_q <= 1'b0;
            pwm_q   <= '0;
            ps_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            pflag_q <= pflag_d;
            armed_q <= armed_d;
            pwm_q   <= pwm_d;
            ps_q    <= boundary;
            ack_q   <= ack_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign load_ack     = ack_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: edge- and centre-aligned instances checked against a
// period-position reference model, plus duty tables and scripted period windows.
module tb_pwm_multi_gen;

    localparam int M  = 10;
    localparam int PC = 2 * (M - 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        duty_load = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] duty_in = '0;
    logic [3:0]  pwm_e, pwm_c;
    logic        ps_e, ps_c, ack_e, ack_c;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwm_multi_gen #(
        .CLK_FREQ(1000), .PWM_FREQ(100), .NUM_CH(4), .DUTY_W(8), .CENTER(0)
    ) u_edge (
        .clk(clk), .reset(reset), .duty_in(duty_in), .duty_load(duty_load),
        .enable(enable), .pwm_out(pwm_e), .period_start(ps_e), .load_ack(ack_e)
    );

    pwm_multi_gen #(
        .CLK_FREQ(1000), .PWM_FREQ(100), .NUM_CH(4), .DUTY_W(8), .CENTER(1)
    ) u_center (
        .clk(clk), .reset(reset), .duty_in(duty_in), .duty_load(duty_load),
        .enable(enable), .pwm_out(pwm_c), .period_start(ps_c), .load_ack(ack_c)
    );

    // Reference model: position inside the period is derived from cycles since reset.
    int         t_m [2];
    int         act_m [2][4];
    int         pend_m [2][4];
    bit         pflag_m [2];
    bit         armed_m [2];
    logic [3:0] xp_pwm [2];
    logic       xp_ps [2];
    logic       xp_ack [2];

    function automatic int pos(input int m, input int t);
        int p;
        if (m == 0) return t % M;
        p = t % PC;
        return (p < M) ? p : PC - p;
    endfunction

    task automatic model_step(input int m);
        int c;
        bit bnd;
        if (reset) begin
            t_m[m] = 0;
            pflag_m[m] = 1'b0;
            armed_m[m] = 1'b0;
            xp_pwm[m] = '0;
            xp_ps[m] = 1'b0;
            xp_ack[m] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                act_m[m][i] = 0;
                pend_m[m][i] = 0;
            end
            return;
        end
        c = pos(m, t_m[m]);
        bnd = (pos(m, t_m[m] + 1) == 0);
        for (int i = 0; i < 4; i++) begin
            xp_pwm[m][i] = armed_m[m] && (c < (act_m[m][i] * M) / 256);
        end
        xp_ps[m] = bnd;
        xp_ack[m] = 1'b0;
        if (duty_load && bnd) begin
            for (int i = 0; i < 4; i++) act_m[m][i] = int'(duty_in[i*8 +: 8]);
            pflag_m[m] = 1'b0;
            xp_ack[m] = 1'b1;
        end else if (bnd && pflag_m[m]) begin
            for (int i = 0; i < 4; i++) act_m[m][i] = pend_m[m][i];
            pflag_m[m] = 1'b0;
            xp_ack[m] = 1'b1;
        end else if (duty_load) begin
            for (int i = 0; i < 4; i++) pend_m[m][i] = int'(duty_in[i*8 +: 8]);
            pflag_m[m] = 1'b1;
        end
        if (!enable) armed_m[m] = 1'b0;
        else if (bnd) armed_m[m] = 1'b1;
        t_m[m] = t_m[m] + 1;
    endtask

    task automatic check_model;
        n_chk++;
        if ({pwm_e, ps_e, ack_e} !== {xp_pwm[0], xp_ps[0], xp_ack[0]}) begin
            n_fail++;
            $display("FAIL model_edge @%0t: got pwm=%b ps=%b ack=%b, want pwm=%b ps=%b ack=%b",
                     $time, pwm_e, ps_e, ack_e, xp_pwm[0], xp_ps[0], xp_ack[0]);
        end
        n_chk++;
        if ({pwm_c, ps_c, ack_c} !== {xp_pwm[1], xp_ps[1], xp_ack[1]}) begin
            n_fail++;
            $display("FAIL model_center @%0t: got pwm=%b ps=%b ack=%b, want pwm=%b ps=%b ack=%b",
                     $time, pwm_c, ps_c, ack_c, xp_pwm[1], xp_ps[1], xp_ack[1]);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model();
    endtask

    task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic wait_ps(input int m);
        int k;
        k = 0;
        tick();
        while (((m == 0) ? ps_e : ps_c) !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_ps_timeout: got no period_start in 40 cycles, want one");
        end
    endtask

    // Count high cycles per channel and period_start pulses over len cycles.
    task automatic measure(input int m, input int len, output int hi [4], output int nps,
                           output logic [3:0] first);
        logic [3:0] p;
        nps = 0;
        first = '0;
        for (int i = 0; i < 4; i++) hi[i] = 0;
        for (int k = 0; k < len; k++) begin
            tick();
            p = (m == 0) ? pwm_e : pwm_c;
            if (k == 0) first = p;
            for (int i = 0; i < 4; i++) hi[i] += int'(p[i]);
            nps += int'((m == 0) ? ps_e : ps_c);
        end
    endtask

    typedef struct {
        logic [7:0] duty;
        int         hi_edge;
        int         hi_center;
    } duty_vec_t;

    typedef struct {
        int         ld_at;
        logic [7:0] ld_val;
        int         ld2_at;
        logic [7:0] ld2_val;
        int         en_lo_at;
        int         en_hi_at;
        int         rst_at;
        logic [9:0] wav;
        int         acks;
    } win_t;

    duty_vec_t dv [9];
    win_t      wins [7];
    int        hi [4];
    int        nps;
    int        acks;
    logic [3:0] first;
    logic [9:0] wav;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        dv[0] = '{8'd128, 5, 9};
        dv[1] = '{8'd0,   0, 0};
        dv[2] = '{8'd255, 9, 17};
        dv[3] = '{8'd26,  1, 1};
        dv[4] = '{8'd64,  2, 3};
        dv[5] = '{8'd25,  0, 0};
        dv[6] = '{8'd230, 8, 15};
        dv[7] = '{8'd52,  2, 3};
        dv[8] = '{8'd192, 7, 13};

        //         ld  val     ld2 val    enlo enhi rst  waveform (bit0 = 1st cycle)  acks
        wins[0] = '{3,  8'd128, 6,  8'd64, -1,  -1,  -1,  10'b0001111111, 1};
        wins[1] = '{-1, 8'd0,   -1, 8'd0,  -1,  -1,  -1,  10'b0000000011, 0};
        wins[2] = '{9,  8'd192, -1, 8'd0,  -1,  -1,  -1,  10'b0000000011, 1};
        wins[3] = '{5,  8'd128, -1, 8'd0,  -1,  -1,  -1,  10'b0001111111, 1};
        wins[4] = '{-1, 8'd0,   -1, 8'd0,  2,   5,   -1,  10'b0000000111, 0};
        wins[5] = '{-1, 8'd0,   -1, 8'd0,  -1,  -1,  -1,  10'b0000011111, 0};
        wins[6] = '{2,  8'd64,  -1, 8'd0,  -1,  -1,  4,   10'b0000001111, 0};

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        expect_val("reset_pwm_edge", 32'(pwm_e), 32'h0);
        expect_val("reset_flags_edge", 32'({ps_e, ack_e}), 32'h0);
        expect_val("reset_pwm_center", 32'(pwm_c), 32'h0);

        // Mixed duties, arming and loading at the same boundary
        reset = 1'b0;
        enable = 1'b1;
        duty_in = {8'd26, 8'd255, 8'd0, 8'd128};
        duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
        wait_ps(0);
        expect_val("mix_ack_at_start", 32'(ack_e), 32'h1);
        measure(0, M, hi, nps, first);
        expect_val("mix_rise_together", 32'(first), 32'hd);
        expect_val("mix_ch0_high", 32'(hi[0]), 32'd5);
        expect_val("mix_ch1_high", 32'(hi[1]), 32'd0);
        expect_val("mix_ch2_high", 32'(hi[2]), 32'd9);
        expect_val("mix_ch3_high", 32'(hi[3]), 32'd1);

        // Duty table, edge and centre instances
        for (int v = 0; v < 9; v++) begin
            duty_in = {4{dv[v].duty}};
            duty_load = 1'b1;
            tick();
            duty_load = 1'b0;
            wait_ps(0);
            measure(0, M, hi, nps, first);
            for (int i = 0; i < 4; i++) begin
                expect_val($sformatf("tbl_edge_d%0d_ch%0d", dv[v].duty, i), 32'(hi[i]),
                           32'(dv[v].hi_edge));
            end
            expect_val($sformatf("tbl_edge_d%0d_ps", dv[v].duty), 32'(nps), 32'd1);
            wait_ps(1);
            measure(1, PC, hi, nps, first);
            expect_val($sformatf("tbl_center_d%0d_ch0", dv[v].duty), 32'(hi[0]),
                       32'(dv[v].hi_center));
            expect_val($sformatf("tbl_center_d%0d_ps", dv[v].duty), 32'(nps), 32'd1);
        end

        // Scripted periods; each window starts on a visible cnt == 0
        wait_ps(0);
        for (int w = 0; w < 7; w++) begin
            wav = '0;
            acks = 0;
            for (int k = 1; k <= M; k++) begin
                duty_load = (k - 1 == wins[w].ld_at) || (k - 1 == wins[w].ld2_at);
                duty_in = (k - 1 == wins[w].ld2_at) ? {4{wins[w].ld2_val}} : {4{wins[w].ld_val}};
                if (k - 1 == wins[w].en_lo_at) enable = 1'b0;
                if (k - 1 == wins[w].en_hi_at) enable = 1'b1;
                reset = (k - 1 == wins[w].rst_at);
                tick();
                wav[k-1] = pwm_e[0];
                acks += int'(ack_e);
            end
            duty_load = 1'b0;
            reset = 1'b0;
            expect_val($sformatf("win%0d_wave", w), 32'(wav), 32'(wins[w].wav));
            expect_val($sformatf("win%0d_acks", w), 32'(acks), 32'(wins[w].acks));
        end

        // After the mid-period reset the pending load is gone: no ack, outputs stay low
        acks = 0;
        wav = '0;
        for (int k = 0; k < M; k++) begin
            tick();
            acks += int'(ack_e);
            wav[k] = |pwm_e;
        end
        expect_val("post_reset_no_ack", 32'(acks), 32'h0);
        expect_val("post_reset_low", 32'(wav), 32'h0);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            enable = ($urandom_range(15) != 0);
            duty_load = ($urandom_range(7) == 0);
            duty_in = $urandom;
            if ($urandom_range(3) == 0) duty_in[7:0] = ($urandom_range(1) == 0) ? 8'h00 : 8'hff;
            reset = ($urandom_range(299) == 0);
            tick();
        end
        reset = 1'b0;
        duty_load = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
